// File: rtl/tawas_load_wb_arb.sv
// Late-load write-back scheduler: per-source return FIFOs, slice-conflict arbitration and a
// RAW scoreboard. Define TAWAS_WB_BYPASS_EN to let a return issue in its push cycle.
module tawas_load_wb_arb #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        issue_vld_i,
    input  logic [1:0]  issue_slice_i,
    input  logic [2:0]  issue_sel_i,
    output logic [31:0] sb_pending_o,

    input  logic [3:0]  wb_block_i,

    input  logic        axi_rtn_vld_i,
    output logic        axi_rtn_rdy_o,
    input  logic [1:0]  axi_rtn_slice_i,
    input  logic [2:0]  axi_rtn_sel_i,
    input  logic [31:0] axi_rtn_data_i,

    input  logic        rac_rtn_vld_i,
    output logic        rac_rtn_rdy_o,
    input  logic [1:0]  rac_rtn_slice_i,
    input  logic [2:0]  rac_rtn_sel_i,
    input  logic [31:0] rac_rtn_data_i,

    output logic        axi_load_vld_o,
    output logic [1:0]  axi_load_slice_o,
    output logic [2:0]  axi_load_sel_o,
    output logic [31:0] axi_load_o,

    output logic        raccoon_load_vld_o,
    output logic [1:0]  raccoon_load_slice_o,
    output logic [2:0]  raccoon_load_sel_o,
    output logic [31:0] raccoon_load_o
);

    // Entry layout: {slice[36:35], sel[34:32], data[31:0]}; index 0 = AXI, 1 = Raccoon.
    localparam int unsigned EntW = 37;

    typedef enum logic {PriAxi, PriRac} pri_e;

    logic [EntW-1:0]  mem_q [2][DEPTH];
    logic [PTR_W-1:0] wptr_q [2];
    logic [PTR_W-1:0] wptr_d [2];
    logic [PTR_W-1:0] rptr_q [2];
    logic [PTR_W-1:0] rptr_d [2];
    logic [PTR_W:0]   cnt_q [2];
    logic [PTR_W:0]   cnt_d [2];
    pri_e             rr_q, rr_d;
    logic [1:0]       vld_q, vld_d;
    logic [EntW-1:0]  ent_q [2];
    logic [EntW-1:0]  ent_d [2];
    logic [31:0]      sb_q, sb_d;

    logic [EntW-1:0]  rtn_ent [2];
    logic [EntW-1:0]  head [2];
    logic [1:0]       rtn_vld, rdy, push, empty, byp, head_vld, elig, issue, pop, wr;
    logic             collide;

    always_comb begin
        rtn_vld    = {rac_rtn_vld_i, axi_rtn_vld_i};
        rtn_ent[0] = {axi_rtn_slice_i, axi_rtn_sel_i, axi_rtn_data_i};
        rtn_ent[1] = {rac_rtn_slice_i, rac_rtn_sel_i, rac_rtn_data_i};
        rdy        = '0;
        push       = '0;
        empty      = '0;
        byp        = '0;
        head_vld   = '0;
        elig       = '0;
        for (int s = 0; s < 2; s++) begin
            rdy[s]   = cnt_q[s] != (PTR_W+1)'(DEPTH);
            push[s]  = rtn_vld[s] & rdy[s];
            empty[s] = cnt_q[s] == '0;
`ifdef TAWAS_WB_BYPASS_EN
            byp[s]   = empty[s] & push[s];
`else
            byp[s]   = 1'b0;
`endif
            head_vld[s] = ~empty[s] | byp[s];
            head[s]     = empty[s] ? rtn_ent[s] : mem_q[s][rptr_q[s]];
            elig[s]     = head_vld[s] & ~wb_block_i[head[s][36:35]];
        end
    end

    // Only identical {slice,sel} targets collide; distinct targets write back together.
    always_comb begin
        collide  = elig[0] & elig[1] & (head[0][36:32] == head[1][36:32]);
        issue[0] = elig[0] & (~collide | (rr_q == PriAxi));
        issue[1] = elig[1] & (~collide | (rr_q == PriRac));
        rr_d     = rr_q;
        if (collide) begin
            rr_d = (rr_q == PriAxi) ? PriRac : PriAxi;
        end
    end

    always_comb begin
        pop   = '0;
        wr    = '0;
        vld_d = issue;
        for (int s = 0; s < 2; s++) begin
            pop[s]    = issue[s] & ~empty[s];
            // A bypassed return that issues never enters the FIFO.
            wr[s]     = push[s] & ~(issue[s] & byp[s]);
            wptr_d[s] = wptr_q[s] + PTR_W'(wr[s]);
            rptr_d[s] = rptr_q[s] + PTR_W'(pop[s]);
            cnt_d[s]  = cnt_q[s] + (PTR_W+1)'(wr[s]) - (PTR_W+1)'(pop[s]);
            ent_d[s]  = issue[s] ? head[s] : ent_q[s];
        end
    end

    // Clear on observed write-back, then set on issue so a same-cycle set wins.
    always_comb begin
        sb_d = sb_q;
        if (vld_q[0]) begin
            sb_d[ent_q[0][36:32]] = 1'b0;
        end
        if (vld_q[1]) begin
            sb_d[ent_q[1][36:32]] = 1'b0;
        end
        if (issue_vld_i) begin
            sb_d[{issue_slice_i, issue_sel_i}] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= '0;
                rptr_q[s] <= '0;
                cnt_q[s]  <= '0;
                ent_q[s]  <= '0;
            end
            rr_q  <= PriAxi;
            vld_q <= '0;
            sb_q  <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wptr_q[s] <= wptr_d[s];
                rptr_q[s] <= rptr_d[s];
                cnt_q[s]  <= cnt_d[s];
                ent_q[s]  <= ent_d[s];
            end
            rr_q  <= rr_d;
            vld_q <= vld_d;
            sb_q  <= sb_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int s = 0; s < 2; s++) begin
            if (wr[s]) begin
                mem_q[s][wptr_q[s]] <= rtn_ent[s];
            end
        end
    end

    assign axi_rtn_rdy_o        = rdy[0];
    assign rac_rtn_rdy_o        = rdy[1];
    assign sb_pending_o         = sb_q;
    assign axi_load_vld_o       = vld_q[0];
    assign axi_load_slice_o     = ent_q[0][36:35];
    assign axi_load_sel_o       = ent_q[0][34:32];
    assign axi_load_o           = ent_q[0][31:0];
    assign raccoon_load_vld_o   = vld_q[1];
    assign raccoon_load_slice_o = ent_q[1][36:35];
    assign raccoon_load_sel_o   = ent_q[1][34:32];
    assign raccoon_load_o       = ent_q[1][31:0];

endmodule

// File: tb/tb_tawas_load_wb_arb.sv
// Bench for tawas_load_wb_arb: directed scenarios plus random traffic, with a scoreboard monitor
// checking per-source order, write-back blocking, collisions and the pending-load scoreboard.
module tb_tawas_load_wb_arb;

`ifdef TAWAS_WB_BYPASS_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_vld = 1'b0;
    logic [1:0]  issue_slice = '0;
    logic [2:0]  issue_sel = '0;
    logic [31:0] sb_pending;
    logic [3:0]  wb_block = '0;
    logic        axi_rtn_vld = 1'b0, rac_rtn_vld = 1'b0;
    logic        axi_rtn_rdy, rac_rtn_rdy;
    logic [1:0]  axi_rtn_slice = '0, rac_rtn_slice = '0;
    logic [2:0]  axi_rtn_sel = '0, rac_rtn_sel = '0;
    logic [31:0] axi_rtn_data = '0, rac_rtn_data = '0;
    logic        axi_load_vld, rac_load_vld;
    logic [1:0]  axi_load_slice, rac_load_slice;
    logic [2:0]  axi_load_sel, rac_load_sel;
    logic [31:0] axi_load, rac_load;

    int checks = 0;
    int errors = 0;

    logic [36:0] axi_q[$];
    logic [36:0] rac_q[$];
    logic [31:0] sb_model = '0;
    logic [3:0]  wb_prev = '0;

    always #5 clk = ~clk;

    tawas_load_wb_arb dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .issue_vld_i         (issue_vld),
        .issue_slice_i       (issue_slice),
        .issue_sel_i         (issue_sel),
        .sb_pending_o        (sb_pending),
        .wb_block_i          (wb_block),
        .axi_rtn_vld_i       (axi_rtn_vld),
        .axi_rtn_rdy_o       (axi_rtn_rdy),
        .axi_rtn_slice_i     (axi_rtn_slice),
        .axi_rtn_sel_i       (axi_rtn_sel),
        .axi_rtn_data_i      (axi_rtn_data),
        .rac_rtn_vld_i       (rac_rtn_vld),
        .rac_rtn_rdy_o       (rac_rtn_rdy),
        .rac_rtn_slice_i     (rac_rtn_slice),
        .rac_rtn_sel_i       (rac_rtn_sel),
        .rac_rtn_data_i      (rac_rtn_data),
        .axi_load_vld_o      (axi_load_vld),
        .axi_load_slice_o    (axi_load_slice),
        .axi_load_sel_o      (axi_load_sel),
        .axi_load_o          (axi_load),
        .raccoon_load_vld_o  (rac_load_vld),
        .raccoon_load_slice_o(rac_load_slice),
        .raccoon_load_sel_o  (rac_load_sel),
        .raccoon_load_o      (rac_load)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_axi(input logic v, input logic [1:0] sl, input logic [2:0] se,
                           input logic [31:0] d);
        axi_rtn_vld = v; axi_rtn_slice = sl; axi_rtn_sel = se; axi_rtn_data = d;
    endtask

    task automatic set_rac(input logic v, input logic [1:0] sl, input logic [2:0] se,
                           input logic [31:0] d);
        rac_rtn_vld = v; rac_rtn_slice = sl; rac_rtn_sel = se; rac_rtn_data = d;
    endtask

    // Monitor: sampled mid-cycle, decoupled from stimulus.
    always @(negedge clk) begin
        logic [31:0] nxt;
        logic [36:0] exp_e;
        if (!rst_n) begin
            axi_q.delete();
            rac_q.delete();
            sb_model = '0;
            chk("rst_axi_vld", axi_load_vld, 0);
            chk("rst_rac_vld", rac_load_vld, 0);
            chk("rst_sb", sb_pending, 0);
        end else begin
            if (axi_load_vld) begin
                if (axi_q.size() == 0) begin
                    chk("axi_unexpected_wb", axi_q.size(), 1);
                end else begin
                    exp_e = axi_q.pop_front();
                    chk("axi_order", {axi_load_slice, axi_load_sel, axi_load}, exp_e);
                end
                chk("axi_wb_blocked_slice", wb_prev[axi_load_slice], 0);
            end
            if (rac_load_vld) begin
                if (rac_q.size() == 0) begin
                    chk("rac_unexpected_wb", rac_q.size(), 1);
                end else begin
                    exp_e = rac_q.pop_front();
                    chk("rac_order", {rac_load_slice, rac_load_sel, rac_load}, exp_e);
                end
                chk("rac_wb_blocked_slice", wb_prev[rac_load_slice], 0);
            end
            if (axi_load_vld && rac_load_vld)
                chk("same_tag_same_cycle", {axi_load_slice, axi_load_sel} ==
                    {rac_load_slice, rac_load_sel}, 0);
            chk("sb_pending", sb_pending, sb_model);
            nxt = sb_model;
            if (axi_load_vld) nxt[{axi_load_slice, axi_load_sel}] = 1'b0;
            if (rac_load_vld) nxt[{rac_load_slice, rac_load_sel}] = 1'b0;
            if (issue_vld) nxt[{issue_slice, issue_sel}] = 1'b1;
            sb_model = nxt;
            if (axi_rtn_vld && axi_rtn_rdy)
                axi_q.push_back({axi_rtn_slice, axi_rtn_sel, axi_rtn_data});
            if (rac_rtn_vld && rac_rtn_rdy)
                rac_q.push_back({rac_rtn_slice, rac_rtn_sel, rac_rtn_data});
        end
        wb_prev = wb_block;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) tick();
        rst_n = 1'b1;
        #3;
        chk("reset_axi_rdy", axi_rtn_rdy, 1);
        chk("reset_rac_rdy", rac_rtn_rdy, 1);
        chk("reset_axi_vld", axi_load_vld, 0);
        chk("reset_rac_vld", rac_load_vld, 0);
        chk("reset_axi_tag", {axi_load_slice, axi_load_sel, axi_load}, 0);
        chk("reset_rac_tag", {rac_load_slice, rac_load_sel, rac_load}, 0);
        chk("reset_sb", sb_pending, 0);

        // Single AXI return slice1 reg3.
        tick(); issue_vld = 1; issue_slice = 1; issue_sel = 3;
        tick(); issue_vld = 0; #3; chk("t1_sb_set", sb_pending[11], 1);
        tick(); set_axi(1, 1, 3, 32'hDEADBEEF);
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 1) axi_rtn_vld = 0;
            #3;
            chk("t1_axi_vld", axi_load_vld, c == Lat);
            if (c == Lat) begin
                chk("t1_sel", axi_load_sel, 3);
                chk("t1_data", axi_load, 32'hDEADBEEF);
            end
        end
        chk("t1_sb_clear", sb_pending[11], 0);

        // Collision on slice2 reg5: AXI first, then Raccoon wins the next collision.
        tick(); set_axi(1, 2, 5, 32'h1111_0000); set_rac(1, 2, 5, 32'h2222_0000);
        for (int c = 1; c <= Lat + 2; c++) begin
            tick();
            if (c == 1) begin axi_rtn_vld = 0; rac_rtn_vld = 0; end
            #3;
            chk("t2_axi_first", axi_load_vld, c == Lat);
            chk("t2_rac_second", rac_load_vld, c == Lat + 1);
        end
        tick(); set_axi(1, 2, 5, 32'h1111_0001); set_rac(1, 2, 5, 32'h2222_0001);
        for (int c = 1; c <= Lat + 2; c++) begin
            tick();
            if (c == 1) begin axi_rtn_vld = 0; rac_rtn_vld = 0; end
            #3;
            chk("t2b_rac_first", rac_load_vld, c == Lat);
            chk("t2b_axi_second", axi_load_vld, c == Lat + 1);
        end

        // Slice 0 blocked for 5 cycles: Raccoon (slice3) unaffected.
        tick(); wb_block = 4'b0001;
        set_axi(1, 0, 1, 32'hA0A0_0000); set_rac(1, 3, 2, 32'hB0B0_0000);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 1) begin axi_rtn_vld = 0; rac_rtn_vld = 0; end
            if (c == 5) wb_block = 4'b0000;
            #3;
            chk("t3_axi_held", axi_load_vld, c == 6);
            chk("t3_rac_free", rac_load_vld, c == Lat);
        end

        // Fill AXI FIFO while all slices blocked, then drain back-to-back.
        tick(); wb_block = 4'hF;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            set_axi(1, 2'(i), 3'(i + 1), 32'hC000_0000 + 32'(i));
        end
        tick(); axi_rtn_vld = 0; #3;
        chk("t4_rdy_full", axi_rtn_rdy, 0);
        wb_block = 4'h0;
        for (int c = 1; c <= 5; c++) begin
            tick(); #3;
            chk("t4_drain_vld", axi_load_vld, c <= 4);
            if (c == 1) chk("t4_rdy_again", axi_rtn_rdy, 1);
        end

        // Issue on a bit in the same cycle its write-back is presented: set wins.
        tick(); issue_vld = 1; issue_slice = 3; issue_sel = 7;
        tick(); issue_vld = 0; set_axi(1, 3, 7, 32'h7777_7777);
        for (int c = 1; c <= Lat; c++) begin
            tick();
            if (c == 1) axi_rtn_vld = 0;
            if (c == Lat) begin issue_vld = 1; issue_slice = 3; issue_sel = 7; end
            #3;
            if (c == Lat) chk("t5_axi_vld", axi_load_vld, 1);
        end
        tick(); issue_vld = 0; #3;
        chk("t5_sb31_kept", sb_pending[31], 1);

        // Reset mid-operation with queued entries and pending bits.
        wb_block = 4'hF;
        for (int i = 0; i < 5; i++) begin
            tick();
            issue_vld = 1; issue_slice = 2'(i); issue_sel = 3'(i + 2);
            if (i < 3) set_axi(1, 2'(i), 3'(i), 32'hE000_0000 + 32'(i));
            else axi_rtn_vld = 0;
        end
        tick(); issue_vld = 0; #3;
        rst_n = 1'b0; #1;
        chk("t6_axi_vld", axi_load_vld, 0);
        chk("t6_rac_vld", rac_load_vld, 0);
        chk("t6_sb_zero", sb_pending, 0);
        tick(); tick(); rst_n = 1'b1; wb_block = 4'h0;
        for (int c = 0; c < 6; c++) begin
            tick(); #3;
            chk("t6_no_wb_axi", axi_load_vld, 0);
            chk("t6_no_wb_rac", rac_load_vld, 0);
        end

        // Random traffic: narrow tag space for frequent collisions.
        for (int c = 0; c < 600; c++) begin
            tick();
            set_axi(($urandom % 3) == 0, 2'($urandom % 4), 3'($urandom % 2), $urandom);
            set_rac(($urandom % 3) == 0, 2'($urandom % 4), 3'($urandom % 2), $urandom);
            wb_block = 4'($urandom & $urandom);
            issue_vld = $urandom % 2;
            issue_slice = 2'($urandom);
            issue_sel = 3'($urandom);
        end
        tick();
        axi_rtn_vld = 0; rac_rtn_vld = 0; issue_vld = 0; wb_block = 4'h0;
        w = 0;
        while ((axi_q.size() != 0 || rac_q.size() != 0) && w < 40) begin
            tick();
            w++;
        end
        repeat (3) tick();
        chk("drain_axi_empty", axi_q.size(), 0);
        chk("drain_rac_empty", rac_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
